// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch/decode sequencer driving pc, instruction memory and execute handshake
module fetch_ctrl #(
  parameter int IW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          areset,
  input  logic [AW-1:0] pc_value,
  output logic          pc_en,
  output logic          pc_jump,
  output logic [AW-1:0] pc_jaddr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [IW-1:0] imem_rdata,
  input  logic          z_flag,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [IW-1:0] ir,
  output logic          halted,
  output logic          illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, UPDATE, HALT} state_t;
  state_t state, nxt;
  logic jump_r;
  logic take;
  logic [3:0] op;
  assign op = ir[IW-1:IW-4];
  // state, instruction register and the branch decision captured in DECODE
  always_ff @(posedge clk) begin
    if (areset) begin
      state    <= FETCH;
      ir       <= '0;
      jump_r   <= 1'b0;
      pc_jaddr <= '0;
    end else begin
      state <= nxt;
      if (state == FETCH && imem_ready) ir <= imem_rdata;
      if (state == DECODE) begin
        jump_r   <= take;
        pc_jaddr <= ir[AW-1:0];
      end
    end
  end
  // next state and state-derived outputs
  always_comb begin
    nxt       = state;
    take      = (op == 4'h8) || (op == 4'h9 && z_flag) || (op == 4'hA && !z_flag);
    imem_req  = state == FETCH;
    imem_addr = imem_req ? pc_value : '0;
    pc_en     = state == UPDATE;
    pc_jump   = pc_en && jump_r;
    ex_valid  = state == EXEC;
    halted    = state == HALT;
    illegal   = state == DECODE && op >= 4'hB && op <= 4'hE;
    case (state)
      FETCH:   nxt = imem_ready ? DECODE : FETCH;
      DECODE:  nxt = op == 4'hF ? HALT : (op >= 4'h1 && op <= 4'h7) ? EXEC : UPDATE;
      EXEC:    nxt = ex_ready ? UPDATE : EXEC;
      UPDATE:  nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench with an architectural program model and a pc register stand-in
module tb_fetch_ctrl;
  logic clk = 0, areset = 1;
  logic [7:0] pc_value, pc_jaddr, imem_addr;
  logic pc_en, pc_jump, imem_req, imem_ready = 0, z_flag, ex_valid, ex_ready = 0, halted, illegal;
  logic [15:0] imem_rdata, ir;
  logic [15:0] mem [256];
  bit zseq [512];
  logic [8:0] idx;
  int mode = 1, fcnt = 0, ecnt = 0;
  int errors = 0, checks = 0;

  fetch_ctrl dut (.clk(clk), .areset(areset), .pc_value(pc_value), .pc_en(pc_en), .pc_jump(pc_jump),
    .pc_jaddr(pc_jaddr), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .z_flag(z_flag), .ex_valid(ex_valid), .ex_ready(ex_ready), .ir(ir),
    .halted(halted), .illegal(illegal));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pc_value <= areset ? 8'h00 : pc_en ? (pc_jump ? pc_jaddr : pc_value + 8'd1) : pc_value;
    idx <= areset ? 9'd0 : idx + {8'd0, pc_en};
  end
  assign imem_rdata = mem[imem_addr];
  assign z_flag = zseq[idx];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  typedef struct {logic [7:0] addr; logic [15:0] ir; bit ex, ill, jmp; logic [7:0] ja;} rec_t;
  rec_t q[$];
  rec_t cur;
  bit cur_v, saw_ill, saw_ex, mon_en = 0;
  int cyc, fcyc, hcyc, retired;

  function automatic void build(input int k);
    logic [7:0] pc = 8'h00;
    for (int i = 0; i < k; i++) begin
      rec_t r;
      logic [3:0] op;
      r.addr = pc;
      r.ir = mem[pc];
      op = r.ir[15:12];
      r.ex = op >= 1 && op <= 7;
      r.ill = op >= 11 && op <= 14;
      r.jmp = op == 8 || (op == 9 && zseq[i]) || (op == 10 && !zseq[i]);
      r.ja = r.ir[7:0];
      q.push_back(r);
      if (op == 15) break;
      pc = r.jmp ? r.ja : pc + 8'd1;
    end
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    fcnt = (imem_req && !areset) ? fcnt + 1 : 0;
    ecnt = ex_valid ? ecnt + 1 : 0;
    imem_ready = mode == 0 ? 1'($urandom_range(0, 1)) : mode == 1 ? fcnt >= 3 : 1'b1;
    ex_ready = mode == 0 ? 1'($urandom_range(0, 1)) : mode == 1 ? ecnt >= 4 : 1'b0;
  end

  always @(negedge clk) if (mon_en) begin
    cyc++;
    if (imem_req && imem_ready) begin
      if (q.size() == 0) chk("fetch_expected", 0, 1);
      else begin
        cur = q.pop_front();
        cur_v = 1;
        chk("fetch_addr", imem_addr, cur.addr);
        fcyc = cyc;
        saw_ill = 0;
        saw_ex = 0;
      end
    end
    if (illegal) begin
      saw_ill = 1;
      chk("illegal_cycle", cyc, fcyc + 1);
    end
    if (ex_valid) begin
      if (!saw_ex) chk("ex_start", cyc, fcyc + 2);
      saw_ex = 1;
      chk("ex_ir", ir, cur.ir);
      if (ex_ready) hcyc = cyc;
    end
    if (pc_en) begin
      chk("upd_has_instr", cur_v, 1);
      chk("upd_jump", pc_jump, cur.jmp);
      if (cur.jmp) chk("upd_jaddr", pc_jaddr, cur.ja);
      chk("upd_ir", ir, cur.ir);
      chk("upd_illegal", saw_ill, cur.ill);
      chk("upd_exec", saw_ex, cur.ex);
      chk("upd_latency", cyc, cur.ex ? hcyc + 1 : fcyc + 2);
      cur_v = 0;
      retired++;
    end else chk("jump_idle", pc_jump, 0);
  end

  task automatic do_reset();
    mon_en = 0;
    areset = 1;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    cur_v = 0;
    retired = 0;
    cyc = 0;
    areset = 0;
  endtask

  task automatic run_until(input int k, input int budget);
    int i;
    for (i = 0; i < budget && retired < k; i++) @(negedge clk);
    chk("retire_count", retired, k);
  endtask

  initial begin
    mem = '{default: 16'h0000};
    mem[8'h00] = 16'h0000; mem[8'h01] = 16'h1234; mem[8'h02] = 16'h901d;
    mem[8'h1d] = 16'h901d; mem[8'h1e] = 16'hB000; mem[8'h1f] = 16'h80ff; mem[8'hff] = 16'hA0ff;
    foreach (zseq[i]) zseq[i] = 1'($urandom_range(0, 1));
    zseq[2] = 1; zseq[3] = 0; zseq[6] = 0; zseq[7] = 0; zseq[8] = 1;
    mode = 1;
    do_reset();
    build(14);
    mon_en = 1;
    @(negedge clk);
    chk("rst_imem_req", imem_req, 1);
    chk("rst_imem_addr", imem_addr, 8'h00);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_pc_jump", pc_jump, 0);
    chk("rst_pc_jaddr", pc_jaddr, 8'h00);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ir", ir, 16'h0000);
    run_until(10, 400);
    mon_en = 0;

    foreach (mem[i]) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    foreach (zseq[i]) zseq[i] = 1'($urandom_range(0, 1));
    mode = 0;
    do_reset();
    build(310);
    mon_en = 1;
    run_until(300, 20000);
    mon_en = 0;

    mem[8'h00] = 16'h0000; mem[8'h01] = 16'hF000;
    mode = 1;
    do_reset();
    for (int i = 0; i < 50 && !halted; i++) @(negedge clk);
    chk("halt_reached", halted, 1);
    repeat (20) begin
      @(negedge clk);
      chk("halt_req", imem_req, 0);
      chk("halt_pc_en", pc_en, 0);
      chk("halt_flag", halted, 1);
    end
    chk("halt_pc", pc_value, 8'h01);
    do_reset();
    @(negedge clk);
    chk("post_halt_req", imem_req, 1);
    chk("post_halt_flag", halted, 0);
    chk("post_halt_addr", imem_addr, 8'h00);

    mem[8'h00] = 16'h1234;
    mode = 2;
    do_reset();
    for (int i = 0; i < 50 && !ex_valid; i++) @(negedge clk);
    chk("midop_ex_valid", ex_valid, 1);
    chk("midop_ir", ir, 16'h1234);
    areset = 1;
    @(posedge clk);
    #1;
    areset = 0;
    @(negedge clk);
    chk("midop_rst_ex_valid", ex_valid, 0);
    chk("midop_rst_ir", ir, 16'h0000);
    chk("midop_rst_req", imem_req, 1);
    chk("midop_rst_pc_en", pc_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
